if_id_stage: RTL and testbench

Fetch stage plus IF/ID pipeline register, directly upstream of the ID/EX register. Holds the PC, presents it to instruction memory, and captures the fetched instruction and PC+4 for decode. Applies load-use stalls and EX-resolved jump/JR redirects. Drives ControlMuxSig into ID/EX so that ID/EX loads a bubble whenever the decode slot must not advance. Also keeps saturating stall and flush performance counters.

---
 rtl/if_id_stage.sv | 72 +++++++
 tb/tb_if_id_stage.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// Fetch stage plus IF/ID pipeline register: owns the PC, captures the fetched word
// and PC+4 for decode, applies load-use stalls and EX-resolved redirects.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic [31:0] Instruction_IF,
  output logic [31:0] PC_IF,
  output logic [31:0] Instruction_ID,
  output logic [31:0] PCAddResult_ID,
  output logic        Valid_ID,
  output logic        ControlMuxSig,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
);

  logic [31:0] pc_plus4_s;

  // Sequential PC increment; natural 32-bit wrap from FFFF_FFFC to 0
  assign pc_plus4_s = PC_IF + 32'd4;

  // ID/EX takes a bubble whenever the decode slot is empty, stalled or squashed
  assign ControlMuxSig = Valid_ID & ~Stall & ~Redirect;

  // PC and IF/ID register; Redirect outranks Stall
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PC_IF          <= RESET_PC;
      Instruction_ID <= 32'h0000_0000;
      PCAddResult_ID <= 32'h0000_0000;
      Valid_ID       <= 1'b0;
    end else if (Redirect) begin
      PC_IF          <= RedirectPC;
      Instruction_ID <= NOP_INSTR;
      PCAddResult_ID <= 32'h0000_0000;
      Valid_ID       <= 1'b0;
    end else if (Stall) begin
      PC_IF          <= PC_IF;
      Instruction_ID <= Instruction_ID;
      PCAddResult_ID <= PCAddResult_ID;
      Valid_ID       <= Valid_ID;
    end else begin
      PC_IF          <= pc_plus4_s;
      Instruction_ID <= Instruction_IF;
      PCAddResult_ID <= pc_plus4_s;
      Valid_ID       <= 1'b1;
    end
  end

  // Saturating performance counters; a redirect-with-stall counts only as a flush
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      StallCount <= 16'h0000;
      FlushCount <= 16'h0000;
    end else if (Redirect) begin
      StallCount <= StallCount;
      FlushCount <= (FlushCount == 16'hFFFF) ? FlushCount : FlushCount + 16'd1;
    end else if (Stall) begin
      StallCount <= (StallCount == 16'hFFFF) ? StallCount : StallCount + 16'd1;
      FlushCount <= FlushCount;
    end else begin
      StallCount <= StallCount;
      FlushCount <= FlushCount;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage; instruction memory returns addr | A000_0000.
module tb_if_id_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_if;
  logic [31:0] pc_if;
  logic [31:0] instr_id;
  logic [31:0] pcadd_id;
  logic        valid_id;
  logic        cms;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  int checks;
  int failures;

  if_id_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
    .Clk(clk), .Reset(rst), .Stall(stall), .Redirect(redirect), .RedirectPC(redirect_pc),
    .Instruction_IF(instr_if), .PC_IF(pc_if), .Instruction_ID(instr_id),
    .PCAddResult_ID(pcadd_id), .Valid_ID(valid_id), .ControlMuxSig(cms),
    .StallCount(stall_count), .FlushCount(flush_count)
  );

  assign instr_if = pc_if | 32'hA000_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0000_0000;
    step();
    step();
    checks++; if (pc_if !== 32'h0000_0000) begin failures++; $display("FAIL reset_pc: got %h exp %h", pc_if, 32'h0000_0000); end
    checks++; if (instr_id !== 32'h0000_0000) begin failures++; $display("FAIL reset_instr: got %h exp %h", instr_id, 32'h0000_0000); end
    checks++; if (pcadd_id !== 32'h0000_0000) begin failures++; $display("FAIL reset_pcadd: got %h exp %h", pcadd_id, 32'h0000_0000); end
    checks++; if (valid_id !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b exp %b", valid_id, 1'b0); end
    checks++; if (stall_count !== 16'h0000 || flush_count !== 16'h0000) begin failures++; $display("FAIL reset_counts: got %h/%h exp 0000/0000", stall_count, flush_count); end
    rst = 1'b0;
    #1;
    checks++; if (cms !== 1'b0) begin failures++; $display("FAIL reset_cms_first: got %b exp %b", cms, 1'b0); end
  endtask

  task automatic test_run();
    step();
    checks++; if (pc_if !== 32'h0000_0004) begin failures++; $display("FAIL run_pc4: got %h exp %h", pc_if, 32'h0000_0004); end
    checks++; if (instr_id !== 32'hA000_0000) begin failures++; $display("FAIL run_instr0: got %h exp %h", instr_id, 32'hA000_0000); end
    checks++; if (pcadd_id !== 32'h0000_0004) begin failures++; $display("FAIL run_pcadd4: got %h exp %h", pcadd_id, 32'h0000_0004); end
    checks++; if (valid_id !== 1'b1 || cms !== 1'b1) begin failures++; $display("FAIL run_valid_cms: got %b%b exp 11", valid_id, cms); end
    step();
    checks++; if (pc_if !== 32'h0000_0008 || instr_id !== 32'hA000_0004) begin failures++; $display("FAIL run_second: got %h/%h exp 00000008/a0000004", pc_if, instr_id); end
    step();
    step();
  endtask

  task automatic test_stall();
    checks++; if (pc_if !== 32'h0000_0010) begin failures++; $display("FAIL stall_start_pc: got %h exp %h", pc_if, 32'h0000_0010); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (cms !== 1'b0) begin failures++; $display("FAIL stall_cms: got %b exp %b", cms, 1'b0); end
      step();
      checks++; if (pc_if !== 32'h0000_0010 || instr_id !== 32'hA000_000C) begin failures++; $display("FAIL stall_hold: got %h/%h exp 00000010/a000000c", pc_if, instr_id); end
    end
    checks++; if (stall_count !== 16'd3) begin failures++; $display("FAIL stall_count: got %h exp %h", stall_count, 16'd3); end
    stall = 1'b0;
    #1;
    checks++; if (cms !== 1'b1) begin failures++; $display("FAIL stall_release_cms: got %b exp %b", cms, 1'b1); end
    step();
    checks++; if (pc_if !== 32'h0000_0014 || instr_id !== 32'hA000_0010 || pcadd_id !== 32'h0000_0014) begin failures++; $display("FAIL stall_resume: got %h/%h/%h exp 00000014/a0000010/00000014", pc_if, instr_id, pcadd_id); end
    step();
    step();
    step();
  endtask

  task automatic test_redirect();
    checks++; if (pc_if !== 32'h0000_0020) begin failures++; $display("FAIL redir_start_pc: got %h exp %h", pc_if, 32'h0000_0020); end
    redirect = 1'b1; redirect_pc = 32'h0000_0400;
    #1;
    checks++; if (cms !== 1'b0) begin failures++; $display("FAIL redir_cms_n: got %b exp %b", cms, 1'b0); end
    step();
    redirect = 1'b0;
    #1;
    checks++; if (pc_if !== 32'h0000_0400) begin failures++; $display("FAIL redir_pc: got %h exp %h", pc_if, 32'h0000_0400); end
    checks++; if (instr_id !== 32'h0000_0000 || pcadd_id !== 32'h0000_0000 || valid_id !== 1'b0) begin failures++; $display("FAIL redir_squash: got %h/%h/%b exp 00000000/00000000/0", instr_id, pcadd_id, valid_id); end
    checks++; if (cms !== 1'b0) begin failures++; $display("FAIL redir_cms_n1: got %b exp %b", cms, 1'b0); end
    checks++; if (flush_count !== 16'd1 || stall_count !== 16'd3) begin failures++; $display("FAIL redir_counts: got %h/%h exp 0001/0003", flush_count, stall_count); end
    step();
    checks++; if (pc_if !== 32'h0000_0404 || instr_id !== 32'hA000_0400 || valid_id !== 1'b1 || cms !== 1'b1) begin failures++; $display("FAIL redir_target: got %h/%h/%b%b exp 00000404/a0000400/11", pc_if, instr_id, valid_id, cms); end
  endtask

  task automatic test_simultaneous();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0080;
    step();
    stall = 1'b0; redirect = 1'b0;
    #1;
    checks++; if (pc_if !== 32'h0000_0080 || valid_id !== 1'b0) begin failures++; $display("FAIL simul_pc: got %h/%b exp 00000080/0", pc_if, valid_id); end
    checks++; if (flush_count !== 16'd2 || stall_count !== 16'd3) begin failures++; $display("FAIL simul_counts: got %h/%h exp 0002/0003", flush_count, stall_count); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    #1;
    checks++; if (pc_if !== 32'hFFFF_FFFC || flush_count !== 16'd3) begin failures++; $display("FAIL wrap_setup: got %h/%h exp fffffffc/0003", pc_if, flush_count); end
    step();
    checks++; if (pc_if !== 32'h0000_0000 || pcadd_id !== 32'h0000_0000 || instr_id !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc: got %h/%h/%h exp 00000000/00000000/fffffffc", pc_if, pcadd_id, instr_id); end
  endtask

  task automatic test_saturation();
    stall = 1'b1;
    for (int i = 0; i < 65531; i++) step();
    checks++; if (stall_count !== 16'hFFFE) begin failures++; $display("FAIL sat_fffe: got %h exp %h", stall_count, 16'hFFFE); end
    step();
    checks++; if (stall_count !== 16'hFFFF) begin failures++; $display("FAIL sat_ffff: got %h exp %h", stall_count, 16'hFFFF); end
    for (int i = 0; i < 5; i++) step();
    checks++; if (stall_count !== 16'hFFFF || pc_if !== 32'h0000_0000) begin failures++; $display("FAIL sat_hold: got %h/%h exp ffff/00000000", stall_count, pc_if); end
    stall = 1'b0;
  endtask

  task automatic test_async_reset();
    redirect = 1'b1; redirect_pc = 32'h0000_0400;
    step();
    redirect = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (pc_if !== 32'h0000_0000 || instr_id !== 32'h0000_0000 || pcadd_id !== 32'h0000_0000) begin failures++; $display("FAIL areset_regs: got %h/%h/%h exp 0", pc_if, instr_id, pcadd_id); end
    checks++; if (valid_id !== 1'b0 || cms !== 1'b0) begin failures++; $display("FAIL areset_valid: got %b%b exp 00", valid_id, cms); end
    checks++; if (stall_count !== 16'h0000 || flush_count !== 16'h0000) begin failures++; $display("FAIL areset_counts: got %h/%h exp 0000/0000", stall_count, flush_count); end
    #1;
    rst = 1'b0;
    step();
    checks++; if (pc_if !== 32'h0000_0004 || instr_id !== 32'hA000_0000 || valid_id !== 1'b1) begin failures++; $display("FAIL areset_restart: got %h/%h/%b exp 00000004/a0000000/1", pc_if, instr_id, valid_id); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_run();
    test_stall();
    test_redirect();
    test_simultaneous();
    test_wrap();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
